// File: rtl/sample_packer.sv
// sample_packer: requantises NCH I/Q channels to 1/2/4/8 bits and packs them into 16-bit words.
// Define SAMPLE_PACKER_DC_EN to add saturating per-component DC correction ahead of quantisation.
module sample_packer #(
  parameter int NCH = 4
) (
  input  logic              source_clk,
  input  logic              source_reset,
  input  logic [8*NCH-1:0]  ch_i,
  input  logic [8*NCH-1:0]  ch_q,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [1:0]        bits_sel,
  input  logic [2:0]        shift,
  input  logic [6:0]        mag_thresh,
  input  logic [16*NCH-1:0] dc_offset,
  output logic [15:0]       out_data,
  output logic              out_en,
  output logic [15:0]       word_count,
  output logic              cfg_err
);

  function automatic logic [7:0] quant(
    input logic [7:0] x,
    input logic [1:0] b,
    input logic [2:0] sh,
    input logic [6:0] th
  );
    logic [7:0] mag;
    logic [7:0] win;
    logic [2:0] s;
    logic [7:0] r;
    mag = x[7] ? (~x + 8'd1) : x;
    s   = (sh > 3'd4) ? 3'd4 : sh;
    win = x >> (3'd4 - s);
    case (b)
      2'd0:    r = {7'b0, x[7]};
      2'd1:    r = {6'b0, x[7], (mag >= {1'b0, th})};
      2'd2:    r = {4'b0, win[3:0]};
      default: r = x;
    endcase
    return r;
  endfunction

`ifdef SAMPLE_PACKER_DC_EN
  function automatic logic [7:0] sat_add(
    input logic [7:0] x,
    input logic [7:0] o
  );
    logic [8:0] s;
    s = {x[7], x} + {o[7], o};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    return s[7:0];
  endfunction
`else
  logic unused_dc;
  assign unused_dc = ^dc_offset;
`endif

  logic [NCH-1:0] mask_q, mask_d;
  logic [1:0]     bsel_q, bsel_d;
  logic [2:0]     shift_q, shift_d;
  logic [6:0]     thr_q, thr_d;
  logic [2:0]     fill_q, fill_d;

  logic [4:0]  bval;
  logic [4:0]  wpair;
  logic [3:0]  pop;
  logic [7:0]  sw_d;
  logic [15:0] smp_d;
  logic [7:0]  ci, cq, qi, qq;
  logic [2:0]  nlast;
  logic        ok_d, last_d;

  logic        s1_vld_q, s1_last_q;
  logic [15:0] s1_smp_q;
  logic [4:0]  s1_sw_q;
  logic [15:0] acc_q, acc_d;
  logic [15:0] data_q;
  logic        en_q, err_q;
  logic [15:0] wc_q;

  // The shadow follows the inputs only while no word is in progress.
  always_comb begin
    mask_d  = mask_q;
    bsel_d  = bsel_q;
    shift_d = shift_q;
    thr_d   = thr_q;
    if (fill_q == 3'd0) begin
      mask_d  = ch_mask;
      bsel_d  = bits_sel;
      shift_d = shift;
      thr_d   = mag_thresh;
    end
  end

  always_comb begin
    bval  = 5'd1 << bsel_d;
    wpair = bval << 1;
    pop   = '0;
    smp_d = '0;
    ci    = '0;
    cq    = '0;
    qi    = '0;
    qq    = '0;
    for (int k = 0; k < NCH; k++) begin
`ifdef SAMPLE_PACKER_DC_EN
      ci = sat_add(ch_i[8*k +: 8], dc_offset[16*k +: 8]);
      cq = sat_add(ch_q[8*k +: 8], dc_offset[16*k+8 +: 8]);
`else
      ci = ch_i[8*k +: 8];
      cq = ch_q[8*k +: 8];
`endif
      qi = quant(ci, bsel_d, shift_d, thr_d);
      qq = quant(cq, bsel_d, shift_d, thr_d);
      if (mask_d[k]) begin
        pop   = pop + 4'd1;
        smp_d = (smp_d << wpair)
              | ({8'b0, qi} << bval)
              | {8'b0, qq};
      end
    end
    sw_d = {3'b0, wpair} * {4'b0, pop};
    ok_d = 1'b1;
    nlast = 3'd0;
    case (sw_d)
      8'd2:    nlast = 3'd7;
      8'd4:    nlast = 3'd3;
      8'd8:    nlast = 3'd1;
      8'd16:   nlast = 3'd0;
      default: ok_d = 1'b0;
    endcase
    last_d = (fill_q == nlast);
    fill_d = (!ok_d || last_d) ? 3'd0 : fill_q + 3'd1;
  end

  assign acc_d = (acc_q << s1_sw_q) | s1_smp_q;

  always_ff @(posedge source_clk) begin
    if (source_reset) begin
      mask_q    <= '0;
      bsel_q    <= '0;
      shift_q   <= '0;
      thr_q     <= '0;
      fill_q    <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_smp_q  <= '0;
      s1_sw_q   <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      wc_q      <= '0;
    end else begin
      mask_q    <= mask_d;
      bsel_q    <= bsel_d;
      shift_q   <= shift_d;
      thr_q     <= thr_d;
      fill_q    <= fill_d;
      s1_vld_q  <= ok_d;
      s1_last_q <= ok_d & last_d;
      s1_smp_q  <= smp_d;
      s1_sw_q   <= sw_d[4:0];
      err_q     <= ~ok_d;
      en_q      <= s1_vld_q & s1_last_q;
      if (s1_vld_q) acc_q <= acc_d;
      if (s1_vld_q && s1_last_q) begin
        data_q <= acc_d;
        wc_q   <= wc_q + 16'd1;
      end
    end
  end

  assign out_data   = data_q;
  assign out_en     = en_q;
  assign word_count = wc_q;
  assign cfg_err    = err_q;

endmodule

// File: doc/sample_packer.md
# sample_packer

Parametrised successor to the fixed 8-bit sample-mode mux that feeds the packet streamer. It takes I/Q samples from NCH ADC channels, applies optional per-channel DC correction, and requantises each component to 1, 2, 4 or 8 bits. It packs the enabled channels MSB-first into 16-bit words with a one-cycle valid strobe. Configuration changes take effect only at word boundaries, so a word never mixes formats.

## Interface
Parameters:
- NCH, 4: number of I/Q channels (1..8).

Ports (clock and reset first):
- source_clk  in  1  sample clock; all logic on the rising edge.
- source_reset  in  1  synchronous, active-high reset.
- ch_i  in  8*NCH  two's-complement I samples; channel k at [8k+7:8k].
- ch_q  in  8*NCH  two's-complement Q samples; same layout as ch_i.
- ch_mask  in  NCH  channel enable; bit k includes channel k.
- bits_sel  in  2  bits per component B: 0→1, 1→2, 2→4, 3→8.
- shift  in  3  4-bit window: bits [7-shift:4-shift]; values >4 act as 4.
- mag_thresh  in  7  2-bit magnitude threshold.
- dc_offset  in  16*NCH  signed DC correction (SAMPLE_PACKER_DC_EN only): I at [16k+7:16k], Q at [16k+15:16k+8].
- out_data  out  16  packed word.
- out_en  out  1  one-cycle strobe; out_data is valid when out_en=1.
- word_count  out  16  count of words emitted; wraps 0xFFFF→0x0000.
- cfg_err  out  1  active shadow configuration is unpackable.

## Operation
- Per-component quantisation of x:
  - B=1: {x<0}.
  - B=2: {x<0, |x|>=mag_thresh}. |−128| is treated as 128.
  - B=4: x[7-shift:4-shift].
  - B=8: x.
- Sample word: concatenation over enabled channels in ascending k of {I_k,Q_k}. The lowest channel occupies the MSBs. Width S = 2·B·popcount(mask).
- Valid S ∈ {2,4,8,16}. The accumulator takes 16/S samples per word; earlier samples sit in the MSBs. For each new sample: acc ← {acc[15-S:0], sample}.
- Shadow configuration (ch_mask, bits_sel, shift, mag_thresh) is loaded in the first cycle after reset and whenever the fill count is 0. Inputs that change mid-word have no effect until the word completes.
- Invalid shadow configuration (mask=0 or S ∉ {2,4,8,16}):
  - cfg_err=1, no out_en, fill count held at 0.
  - The shadow reloads every cycle, so fixing the inputs recovers at the next cycle.
- The final sample of a word asserts out_en for exactly one cycle and increments word_count in the same cycle.
- Reset values:
  - out_data=0, out_en=0, word_count=0, cfg_err=0.
  - Fill count 0; pipeline registers cleared.
- A reset asserted mid-word discards the partial word, and no strobe is emitted. The first sample after reset is the one presented in the first cycle with source_reset low.

## Timing
- Stage 1 registers the DC-corrected, quantised components. Stage 2 registers the accumulator and out_en.
- Latency: the sample presented at cycle t lands in stage 1 at t+1. If it completes a word, out_en=1 at t+2.
- Throughput: one input sample per cycle. At steady state out_en asserts every 16/S cycles. S=16 gives out_en every cycle.
- The shadow loaded at cycle t governs samples entering stage 1 from t onward. Pipeline samples carry their format with them.

## Configuration
- SAMPLE_PACKER_DC_EN defined:
  - Each component gets the signed 8-bit dc_offset added before quantisation.
  - The sum saturates to [−128, +127].
  - Adds one adder per component inside stage 1; latency is unchanged.
- Undefined: the dc_offset port exists but is ignored, and components pass through unmodified.

## Test plan
- **2-bit packing:** NCH=4, mask=0011, bits_sel=1, thresh=20, ch0 I=+50 Q=−3, ch1 I=−100 Q=+1, held → out_data=0x6C6C, out_en every 2nd cycle, word_count +1 per strobe.
- **8-bit passthrough:** mask=0001, bits_sel=3, I=0x12, Q=0x34 → out_data=0x1234, out_en every cycle from t+2, word_count wraps 0xFFFF→0x0000.
- **4-bit window:** mask=0001, bits_sel=2, shift=2, I=0xA5, Q=0x3C → out_data=0x9F9F.
- **Invalid config:** mask=0111, bits_sel=1 (S=12) → cfg_err=1, no out_en. Set mask=0011 → cfg_err=0 next cycle, words resume.
- **Boundary latching and reset:**
  - bits_sel=0, mask=0001 (8 samples/word); switch bits_sel to 3 after 3 samples → current word completes in 1-bit format, next word is 8-bit.
  - Reset after 3 samples → no strobe, word_count=0.
- **DC saturation (SAMPLE_PACKER_DC_EN):** I=+125, dc_offset=+10, B=8 → I byte 0x7F. Without the macro → 0x7D.
